chip_prog_rx: RTL and testbench

Chip-side serial programming receiver. It samples the serial clock/data pair driven by the board FPGA and shifts in the 5-bit programming word. It then latches amplifier gains A1 (2 bits) and A2 (3 bits) and raises `o_ready` to tell the FPGA the chip is programmed. All logic runs on the chip main clock; `i_sclk` and `i_sdin` are treated as asynchronous and oversampled.

---
 rtl/chip_prog_rx.sv | 129 ++++++++++++
 tb/tb_chip_prog_rx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/chip_prog_rx.sv
// Chip-side serial programming receiver: oversamples sclk/sdin, shifts in a
// 5-bit word and latches gains A1/A2, then holds them until reset.
module chip_prog_rx #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_mainclk,
  input  logic       i_resetAll,
  input  logic       i_sclk,
  input  logic       i_sdin,
  output logic [1:0] o_gainA1,
  output logic [2:0] o_gainA2,
  output logic       o_ready,
  output logic       o_frame_err
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   sdin_s;
  logic                   rise;
  logic                   fall;

  logic [4:0]    shreg;
  logic [2:0]    bitcnt;
  logic [CW-1:0] tcnt;

  logic start;
  logic do_shift;
  logic abort;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sdin_s = sdin_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;

  always_ff @(posedge i_mainclk) begin
    if (i_resetAll) state <= S_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    do_shift   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_next = S_SHIFT;
          start      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (rise) begin
          do_shift = 1'b1;
          if (bitcnt == 3'd4) state_next = S_DONE;
        end
        // An edge in the timeout cycle wins over the abort.
        if (!(rise || fall) && tcnt == TO_MAX) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_mainclk) begin
    if (i_resetAll) begin
      sclk_sync   <= '1;
      sdin_sync   <= '0;
      sclk_prev   <= 1'b1;
      shreg       <= '0;
      bitcnt      <= '0;
      tcnt        <= '0;
      o_gainA1    <= '0;
      o_gainA2    <= '0;
      o_ready     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], i_sdin};
      sclk_prev <= sclk_s;

      if (start) begin
        bitcnt <= '0;
        tcnt   <= '0;
      end else if (state == S_SHIFT) begin
        if (rise || fall)    tcnt <= '0;
        else if (tcnt != TO_MAX) tcnt <= tcnt + CW'(1);
      end

      if (do_shift) begin
        shreg  <= {sdin_s, shreg[4:1]};
        bitcnt <= bitcnt + 3'd1;
      end

      if (abort) begin
        shreg       <= '0;
        bitcnt      <= '0;
        o_frame_err <= 1'b1;
      end

      // Outputs are loaded one cycle after entering S_DONE, when shreg
      // already holds the final bit.
      if (state == S_DONE && !o_ready) begin
        o_gainA1    <= shreg[1:0];
        o_gainA2    <= shreg[4:2];
        o_ready     <= 1'b1;
        o_frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chip_prog_rx.sv
// Directed self-checking bench for chip_prog_rx at default parameters.
module tb_chip_prog_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b1;
  logic       sdin = 1'b0;
  logic [1:0] gain_a1;
  logic [2:0] gain_a2;
  logic       ready;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int HALF = 16;

  chip_prog_rx #(.TIMEOUT_CYC(64), .SYNC_STAGES(2)) dut (
    .i_mainclk   (clk),
    .i_resetAll  (rst),
    .i_sclk      (sclk),
    .i_sdin      (sdin),
    .o_gainA1    (gain_a1),
    .o_gainA2    (gain_a2),
    .o_ready     (ready),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // One bit: launch on falling sclk, rising edge after HALF; optional high phase.
  task automatic send_bit(input logic b, input bit hold_high);
    sclk = 1'b0;
    sdin = b;
    tick(HALF);
    sclk = 1'b1;
    if (hold_high) tick(HALF);
  endtask

  task automatic send_word(input logic [1:0] a1, input logic [2:0] a2);
    logic [4:0] w;
    w = {a2, a1};
    for (int i = 0; i < 5; i++) send_bit(w[i], 1'b1);
  endtask

  task automatic chk_out(input string tag, input int a1, input int a2, input int rdy, input int err);
    chk({tag, "_a1"},  32'(gain_a1),   32'(a1));
    chk({tag, "_a2"},  32'(gain_a2),   32'(a2));
    chk({tag, "_rdy"}, 32'(ready),     32'(rdy));
    chk({tag, "_err"}, 32'(frame_err), 32'(err));
  endtask

  initial begin
    tick(1);
    do_reset();
    chk_out("reset", 0, 0, 0, 0);

    // Nominal word A1=2, A2=5: stream 0,1,1,0,1; check ready latency.
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    tick(3);
    chk("nom_rdy_early", 32'(ready), 32'd0);
    tick(1);
    chk("nom_rdy_on_time", 32'(ready), 32'd1);
    chk_out("nom", 2, 5, 1, 0);

    // Abort by timeout after 3 bits.
    do_reset();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    tick(66);
    chk("to_err_early", 32'(frame_err), 32'd0);
    tick(1);
    chk_out("to", 0, 0, 0, 1);
    send_word(2'd3, 3'd7);
    chk_out("to_follow", 3, 7, 1, 0);

    // Reset mid-frame after 2 bits (ready/gains were 1/3/7 before this).
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_out("midrst", 0, 0, 0, 0);
    send_word(2'd1, 3'd6);
    chk_out("midrst_word", 1, 6, 1, 0);

    // Post-done immunity.
    do_reset();
    send_word(2'd2, 3'd5);
    chk_out("done_first", 2, 5, 1, 0);
    send_word(2'd0, 3'd0);
    for (int i = 0; i < 60; i++) begin
      sclk = 1'($urandom_range(1, 0));
      sdin = 1'($urandom_range(1, 0));
      tick(1);
    end
    sclk = 1'b1;
    tick(8);
    chk_out("done_immune", 2, 5, 1, 0);

    // Idle glitches: sub-cycle low pulses between clock edges, redundant highs.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0;
      sdin = 1'b1;
      #3;
      sclk = 1'b1;
      tick(2);
    end
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b1;
      tick(3);
    end
    tick(70);
    chk_out("idle_glitch", 0, 0, 0, 0);
    send_word(2'd1, 3'd3);
    chk_out("idle_word", 1, 3, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
